// File: rtl/maze_game_ctrl.sv
// Maze game sequencer: seed capture, generator handshake, player moves, goal detection.
// Optional generator watchdog enabled by defining MAZE_CTRL_TIMEOUT_EN.
module maze_game_ctrl #(
    parameter int COLS           = 15,
    parameter int ROWS           = 10,
    parameter int START_X        = 0,
    parameter int START_Y        = 0,
    parameter int GOAL_X         = 14,
    parameter int GOAL_Y         = 9,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       btn_start,
    input  logic                       btn_up,
    input  logic                       btn_down,
    input  logic                       btn_left,
    input  logic                       btn_right,
    input  logic                       gen_busy,
    input  logic [ROWS*(COLS+1)-1:0]   h_walls,
    input  logic [(ROWS+1)*COLS-1:0]   v_walls,
    output logic                       gen_enable,
    output logic [31:0]                gen_seed,
    output logic [3:0]                 player_x,
    output logic [3:0]                 player_y,
    output logic [15:0]                move_count,
    output logic [2:0]                 state,
    output logic                       won,
    output logic                       error
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_GEN  = 3'd2,
        S_PLAY = 3'd3,
        S_WON  = 3'd4
    } state_t;

    localparam logic [31:0] LFSR_INIT = 32'hACE10001;
    localparam logic [31:0] LFSR_MASK = 32'h80200003;
    localparam logic [8:0]  V_STRIDE  = 9'(COLS);
    localparam logic [8:0]  H_STRIDE  = 9'(COLS + 1);
    localparam logic [3:0]  X_MAX     = 4'(COLS - 1);
    localparam logic [3:0]  Y_MAX     = 4'(ROWS - 1);
    localparam logic [3:0]  SX        = 4'(START_X);
    localparam logic [3:0]  SY        = 4'(START_Y);
    localparam logic [3:0]  GX        = 4'(GOAL_X);
    localparam logic [3:0]  GY        = 4'(GOAL_Y);

    state_t      st;
    logic [31:0] lfsr;
    logic [31:0] lfsr_next;
    logic        tmo_hit;

    logic [8:0]  v_idx_up;
    logic [8:0]  v_idx_dn;
    logic [8:0]  h_idx_l;
    logic [8:0]  h_idx_r;
    logic [(ROWS+1)*COLS-1:0] v_sh_up;
    logic [(ROWS+1)*COLS-1:0] v_sh_dn;
    logic [ROWS*(COLS+1)-1:0] h_sh_l;
    logic [ROWS*(COLS+1)-1:0] h_sh_r;

    logic        mv_ok;
    logic        goal_hit;
    logic [3:0]  nx;
    logic [3:0]  ny;

    assign state     = st;
    assign lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_MASK : 32'h0);

    // 9-bit indices keep a full 15x15 grid addressable without wrap.
    always_comb begin
        v_idx_up = 9'(player_y) * V_STRIDE + 9'(player_x);
        v_idx_dn = (9'(player_y) + 9'd1) * V_STRIDE + 9'(player_x);
        h_idx_l  = 9'(player_y) * H_STRIDE + 9'(player_x);
        h_idx_r  = h_idx_l + 9'd1;
        v_sh_up  = v_walls >> v_idx_up;
        v_sh_dn  = v_walls >> v_idx_dn;
        h_sh_l   = h_walls >> h_idx_l;
        h_sh_r   = h_walls >> h_idx_r;
    end

    always_comb begin
        mv_ok = 1'b0;
        nx    = player_x;
        ny    = player_y;
        priority case (1'b1)
            btn_up: begin
                if (player_y != 4'd0 && !v_sh_up[0]) begin
                    mv_ok = 1'b1;
                    ny    = player_y - 4'd1;
                end
            end
            btn_down: begin
                if (player_y != Y_MAX && !v_sh_dn[0]) begin
                    mv_ok = 1'b1;
                    ny    = player_y + 4'd1;
                end
            end
            btn_left: begin
                if (player_x != 4'd0 && !h_sh_l[0]) begin
                    mv_ok = 1'b1;
                    nx    = player_x - 4'd1;
                end
            end
            btn_right: begin
                if (player_x != X_MAX && !h_sh_r[0]) begin
                    mv_ok = 1'b1;
                    nx    = player_x + 4'd1;
                end
            end
            default: begin
                mv_ok = 1'b0;
            end
        endcase
        goal_hit = mv_ok && (nx == GX) && (ny == GY);
    end

`ifdef MAZE_CTRL_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] tmo_cnt;
    logic        err_r;

    assign tmo_hit = (st == S_REQ || st == S_GEN) && (tmo_cnt == TMO_LAST);
    assign error   = err_r;

    // Counter restarts whenever REQ or GEN is freshly entered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_cnt <= 32'd0;
            err_r   <= 1'b0;
        end else begin
            if (tmo_hit)
                err_r <= 1'b1;
            if ((st != S_REQ && st != S_GEN) || tmo_hit
                || (st == S_REQ && gen_busy))
                tmo_cnt <= 32'd0;
            else
                tmo_cnt <= tmo_cnt + 32'd1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign error   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            st         <= S_IDLE;
            lfsr       <= LFSR_INIT;
            gen_enable <= 1'b0;
            gen_seed   <= 32'd0;
            player_x   <= SX;
            player_y   <= SY;
            move_count <= 16'd0;
            won        <= 1'b0;
        end else begin
            lfsr <= lfsr_next;
            won  <= 1'b0;
            unique case (st)
                S_IDLE: begin
                    if (btn_start) begin
                        gen_seed   <= lfsr;
                        gen_enable <= 1'b1;
                        st         <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (tmo_hit) begin
                        gen_enable <= 1'b0;
                        st         <= S_IDLE;
                    end else if (gen_busy) begin
                        gen_enable <= 1'b0;
                        st         <= S_GEN;
                    end
                end
                S_GEN: begin
                    if (tmo_hit) begin
                        gen_enable <= 1'b0;
                        st         <= S_IDLE;
                    end else if (!gen_busy) begin
                        player_x   <= SX;
                        player_y   <= SY;
                        move_count <= 16'd0;
                        st         <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (btn_start) begin
                        gen_seed   <= lfsr;
                        gen_enable <= 1'b1;
                        st         <= S_REQ;
                    end else if (mv_ok) begin
                        player_x <= nx;
                        player_y <= ny;
                        if (move_count != 16'hFFFF)
                            move_count <= move_count + 16'd1;
                        if (goal_hit) begin
                            won <= 1'b1;
                            st  <= S_WON;
                        end
                    end
                end
                S_WON: begin
                    if (btn_start) begin
                        gen_seed   <= lfsr;
                        gen_enable <= 1'b1;
                        st         <= S_REQ;
                    end
                end
                default: begin
                    st <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maze_game_ctrl.sv
// Directed bench for maze_game_ctrl: reset, handshake, moves, walls, win, restart.
// Timeout steps run only when MAZE_CTRL_TIMEOUT_EN is defined.
module tb_maze_game_ctrl;

    localparam int COLS = 15;
    localparam int ROWS = 10;
    localparam logic [31:0] INIT = 32'hACE10001;

    logic clk = 1'b0;
    logic rst;
    logic btn_start, btn_up, btn_down, btn_left, btn_right;
    logic gen_busy;
    logic [ROWS*(COLS+1)-1:0] h_walls;
    logic [(ROWS+1)*COLS-1:0] v_walls;
    logic        gen_enable;
    logic [31:0] gen_seed;
    logic [3:0]  player_x, player_y;
    logic [15:0] move_count;
    logic [2:0]  state;
    logic        won;
    logic        error;

    int checks   = 0;
    int failures = 0;
    logic [31:0] m_lfsr = INIT;
    logic [31:0] exp_seed;
    logic [31:0] seed1;

    always #5 clk = ~clk;

    maze_game_ctrl #(
        .COLS(COLS), .ROWS(ROWS),
        .START_X(0), .START_Y(0),
        .GOAL_X(14), .GOAL_Y(9),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_start(btn_start),
        .btn_up(btn_up), .btn_down(btn_down),
        .btn_left(btn_left), .btn_right(btn_right),
        .gen_busy(gen_busy),
        .h_walls(h_walls), .v_walls(v_walls),
        .gen_enable(gen_enable), .gen_seed(gen_seed),
        .player_x(player_x), .player_y(player_y),
        .move_count(move_count), .state(state),
        .won(won), .error(error)
    );

    function automatic logic [31:0] lstep(input logic [31:0] v);
        return {1'b0, v[31:1]} ^ (v[0] ? 32'h80200003 : 32'h0);
    endfunction

    // LFSR reference advances on every edge not under reset.
    task automatic tick;
        @(posedge clk);
        if (!rst) m_lfsr = INIT;
        else m_lfsr = lstep(m_lfsr);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pos(input string tag, input int x, input int y,
                           input int mc);
        chk({tag, "_x"}, 32'(player_x), 32'(x));
        chk({tag, "_y"}, 32'(player_y), 32'(y));
        chk({tag, "_mc"}, 32'(move_count), 32'(mc));
    endtask

    // dirs = {up, down, left, right}
    task automatic move(input logic [3:0] dirs);
        {btn_up, btn_down, btn_left, btn_right} = dirs;
        tick();
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
    endtask

    task automatic press_start;
        btn_start = 1'b1;
        tick();
        btn_start = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_en"}, 32'(gen_enable), 32'd0);
        chk({tag, "_seed"}, gen_seed, 32'd0);
        chk_pos(tag, 0, 0, 0);
        chk({tag, "_won"}, 32'(won), 32'd0);
        chk({tag, "_err"}, 32'(error), 32'd0);
    endtask

    localparam logic [3:0] UP = 4'b1000;
    localparam logic [3:0] DN = 4'b0100;
    localparam logic [3:0] LT = 4'b0010;
    localparam logic [3:0] RT = 4'b0001;

    initial begin
        rst = 1'b0;
        btn_start = 1'b0;
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
        gen_busy = 1'b0;
        h_walls = '0;
        v_walls = '0;

        repeat (5) tick();
        chk_reset_outputs("reset");

        rst = 1'b1;
        repeat (3) tick();
        seed1 = lstep(lstep(lstep(INIT)));
        press_start();
        chk("req_state", 32'(state), 32'd1);
        chk("req_en", 32'(gen_enable), 32'd1);
        chk("seed_3_shifts", gen_seed, seed1);

        repeat (2) tick();
        press_start();
        chk("req_start_ignored_seed", gen_seed, seed1);
        chk("req_en_held", 32'(gen_enable), 32'd1);
        chk("req_state_held", 32'(state), 32'd1);

        gen_busy = 1'b1;
        tick();
        chk("gen_state", 32'(state), 32'd2);
        chk("gen_en_low", 32'(gen_enable), 32'd0);
        repeat (99) tick();
        chk("gen_wait", 32'(state), 32'd2);
        gen_busy = 1'b0;
        tick();
        chk("play_state", 32'(state), 32'd3);
        chk_pos("play_entry", 0, 0, 0);

        move(UP);
        chk_pos("up_border", 0, 0, 0);
        move(RT);
        chk_pos("right_open", 1, 0, 1);
        h_walls[2] = 1'b1;
        move(RT);
        chk_pos("right_wall", 1, 0, 1);
        h_walls = '0;
        v_walls[1*COLS+1] = 1'b1;
        move(DN);
        chk_pos("down_wall", 1, 0, 1);
        v_walls = '0;
        move(DN);
        chk_pos("down_open", 1, 1, 2);
        move(UP | RT);
        chk_pos("prio_up_right", 1, 0, 3);
        move(DN | LT);
        chk_pos("prio_down_left", 1, 1, 4);
        move(LT);
        chk_pos("left_open", 0, 1, 5);
        move(LT);
        chk_pos("left_border", 0, 1, 5);
        move(UP);
        chk_pos("back_origin", 0, 0, 6);

        for (int i = 0; i < 14; i++) move(RT);
        chk_pos("walk_east", 14, 0, 20);
        move(RT);
        chk_pos("right_border", 14, 0, 20);
        for (int i = 0; i < 8; i++) move(DN);
        chk_pos("walk_south", 14, 8, 28);
        chk("pre_goal_won", 32'(won), 32'd0);
        chk("pre_goal_state", 32'(state), 32'd3);
        move(DN);
        chk_pos("goal", 14, 9, 29);
        chk("won_pulse", 32'(won), 32'd1);
        chk("won_state", 32'(state), 32'd4);
        tick();
        chk("won_pulse_end", 32'(won), 32'd0);
        move(UP);
        chk_pos("won_frozen", 14, 9, 29);
        chk("won_state_hold", 32'(state), 32'd4);

        exp_seed = m_lfsr;
        press_start();
        chk("restart_state", 32'(state), 32'd1);
        chk("restart_en", 32'(gen_enable), 32'd1);
        chk("restart_seed", gen_seed, exp_seed);

        gen_busy = 1'b1;
        tick();
        chk("gen2_state", 32'(state), 32'd2);
        rst = 1'b0;
        tick();
        chk_reset_outputs("reset_in_gen");
        gen_busy = 1'b0;
        rst = 1'b1;

`ifdef MAZE_CTRL_TIMEOUT_EN
        press_start();
        gen_busy = 1'b1;
        tick();
        chk("tmo_gen_state", 32'(state), 32'd2);
        repeat (63) tick();
        chk("tmo_before", 32'(state), 32'd2);
        chk("tmo_err_before", 32'(error), 32'd0);
        tick();
        chk("tmo_state", 32'(state), 32'd0);
        chk("tmo_err", 32'(error), 32'd1);
        chk("tmo_en", 32'(gen_enable), 32'd0);
        gen_busy = 1'b0;
        repeat (3) tick();
        chk("tmo_err_sticky", 32'(error), 32'd1);
`else
        repeat (3) tick();
        chk("err_tied", 32'(error), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
